// File: rtl/spi_sub_pkg.sv
// Shared types and helpers for the SPI subordinate sequencer.
package spi_sub_pkg;

  localparam int SPI_BYTE_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_sub_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // A leading edge moves SCLK away from its idle level; a trailing edge returns it.
  function automatic logic edge_is_leading(input logic lvl, input logic chg, input logic pol);
    return chg && (lvl != pol);
  endfunction

  function automatic logic edge_is_trailing(input logic lvl, input logic chg, input logic pol);
    return chg && (lvl == pol);
  endfunction

endpackage

// File: rtl/spi_sub_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pad plus one delay flop for edge detection.
module spi_sub_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic pclk,
  input  logic presetn,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sync_q <= {STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pad};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level && !dly_q;
  assign fall  = !level && dly_q;

endmodule

// File: rtl/spi_sub_ctrl.sv
// SPI subordinate sequencer: pad sync, SCLK edge decode, shift/load enables and byte handshakes.
// Optional frame byte counter enabled by defining SPI_SUB_CTRL_BYTE_CNT_EN.
//
// state  | meaning
// IDLE   | CS_n high; waiting for the synchronised CS_n falling edge
// ACTIVE | frame in progress; SCLK edges drive load/shift enables
module spi_sub_ctrl
  import spi_sub_pkg::*;
#(
  parameter int                    SYNC_STAGES = 2,
  parameter logic [SPI_BYTE_W-1:0] DUMMY_BYTE  = 8'hFF
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  sclk_pad_i,
  input  logic                  cs_n_pad_i,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic [SPI_BYTE_W-1:0] sub_rx,
  output logic [SPI_BYTE_W-1:0] sub_tx,
  output logic                  tx_load,
  output logic                  slave_transfer_shift_en,
  output logic                  slave_receive_shift_en,
  output logic                  busy,
  output logic                  rx_overrun,
  output logic                  tx_underrun,
  input  logic                  clr_status,
  output logic [7:0]            frame_byte_cnt
);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_n_s, cs_rise, cs_fall;

  spi_sub_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .pclk    (pclk),
    .presetn (presetn),
    .pad     (sclk_pad_i),
    .level   (sclk_s),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  spi_sub_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .pclk    (pclk),
    .presetn (presetn),
    .pad     (cs_n_pad_i),
    .level   (cs_n_s),
    .rise    (cs_rise),
    .fall    (cs_fall)
  );

  spi_sub_state_e        state_q, state_d;
  spi_mode_t             mode_q;
  logic [2:0]            bit_cnt;
  logic                  byte_done_q;
  logic                  tx_full_q;
  logic [SPI_BYTE_W-1:0] tx_hold_q;

  logic sclk_chg, leading, trailing;
  logic frame_start, frame_end;
  logic tx_push, overrun_set, underrun_set;

  assign sclk_chg    = sclk_rise || sclk_fall;
  assign leading     = edge_is_leading(sclk_s, sclk_chg, mode_q.cpol);
  assign trailing    = edge_is_trailing(sclk_s, sclk_chg, mode_q.cpol);
  assign frame_start = (state_q == IDLE) && cs_fall;
  assign frame_end   = (state_q == ACTIVE) && cs_rise;

  // FSM: state register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = ACTIVE;
      ACTIVE:  if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. Gating on the synchronised CS_n level suppresses enables on the exit cycle.
  always_comb begin
    busy                    = 1'b0;
    tx_load                 = 1'b0;
    slave_transfer_shift_en = 1'b0;
    slave_receive_shift_en  = 1'b0;
    case (state_q)
      IDLE: tx_load = cs_fall && !cpha;
      ACTIVE: begin
        busy = 1'b1;
        if (!cs_n_s) begin
          if (!mode_q.cpha) begin
            slave_receive_shift_en  = leading;
            tx_load                 = trailing && (bit_cnt == 3'd0);
            slave_transfer_shift_en = trailing && (bit_cnt != 3'd0);
          end else begin
            tx_load                 = leading && (bit_cnt == 3'd0);
            slave_transfer_shift_en = leading && (bit_cnt != 3'd0);
            slave_receive_shift_en  = trailing;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      mode_q      <= '0;
      bit_cnt     <= 3'd0;
      byte_done_q <= 1'b0;
    end else begin
      if (frame_start) mode_q <= '{cpol: cpol, cpha: cpha};
      if (frame_start || frame_end)   bit_cnt <= 3'd0;
      else if (slave_receive_shift_en) bit_cnt <= bit_cnt + 3'd1;
      // Delayed one cycle so the external receive register has taken the last bit.
      byte_done_q <= slave_receive_shift_en && (bit_cnt == 3'd7);
    end
  end

  assign overrun_set = byte_done_q && rx_valid && !rx_ready;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (byte_done_q) begin
      if (!rx_valid || rx_ready) begin
        rx_data  <= sub_rx;
        rx_valid <= 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  assign tx_ready     = !tx_full_q;
  assign tx_push      = tx_valid && !tx_full_q;
  assign underrun_set = tx_load && !tx_full_q && !tx_valid;

  // A push coinciding with a load on an empty holding register bypasses straight to sub_tx.
  always_comb begin
    if (tx_full_q)              sub_tx = tx_hold_q;
    else if (tx_load && tx_valid) sub_tx = tx_data;
    else                        sub_tx = DUMMY_BYTE;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tx_full_q <= 1'b0;
      tx_hold_q <= '0;
    end else if (tx_load) begin
      tx_full_q <= 1'b0;
    end else if (tx_push) begin
      tx_full_q <= 1'b1;
      tx_hold_q <= tx_data;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      if (overrun_set)     rx_overrun <= 1'b1;
      else if (clr_status) rx_overrun <= 1'b0;
      if (underrun_set)    tx_underrun <= 1'b1;
      else if (clr_status) tx_underrun <= 1'b0;
    end
  end

`ifdef SPI_SUB_CTRL_BYTE_CNT_EN
  logic [7:0] byte_cnt_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)                               byte_cnt_q <= 8'd0;
    else if (frame_start)                       byte_cnt_q <= 8'd0;
    else if (byte_done_q && byte_cnt_q != 8'hFF) byte_cnt_q <= byte_cnt_q + 8'd1;
  end

  assign frame_byte_cnt = byte_cnt_q;
`else
  assign frame_byte_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_spi_sub_ctrl.sv
// Directed bench for spi_sub_ctrl with models of the external shift registers and an SPI host.
`timescale 1ns/1ps
module tb_spi_sub_ctrl;

  localparam int H = 8;  // pclk cycles per SCLK half period

  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic       sclk_pad_i = 1'b0;
  logic       cs_n_pad_i = 1'b1;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       rx_ready = 1'b0;
  logic       clr_status = 1'b0;
  logic       mosi = 1'b0;

  logic       tx_ready, rx_valid, tx_load, slave_transfer_shift_en, slave_receive_shift_en;
  logic       busy, rx_overrun, tx_underrun, miso;
  logic [7:0] rx_data, sub_rx, sub_tx, frame_byte_cnt;
  logic [7:0] rx_sr, tx_sr;

  int n_tot = 0;
  int n_bad = 0;
  int n_load = 0, n_tsh = 0, n_rsh = 0, n_both = 0;
  logic [7:0] rx_q[$];

  always #5 pclk = ~pclk;

  spi_sub_ctrl dut (
    .pclk                    (pclk),
    .presetn                 (presetn),
    .sclk_pad_i              (sclk_pad_i),
    .cs_n_pad_i              (cs_n_pad_i),
    .cpol                    (cpol),
    .cpha                    (cpha),
    .tx_data                 (tx_data),
    .tx_valid                (tx_valid),
    .tx_ready                (tx_ready),
    .rx_data                 (rx_data),
    .rx_valid                (rx_valid),
    .rx_ready                (rx_ready),
    .sub_rx                  (sub_rx),
    .sub_tx                  (sub_tx),
    .tx_load                 (tx_load),
    .slave_transfer_shift_en (slave_transfer_shift_en),
    .slave_receive_shift_en  (slave_receive_shift_en),
    .busy                    (busy),
    .rx_overrun              (rx_overrun),
    .tx_underrun             (tx_underrun),
    .clr_status              (clr_status),
    .frame_byte_cnt          (frame_byte_cnt)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rx_sr <= 8'h00;
      tx_sr <= 8'h00;
    end else begin
      if (slave_receive_shift_en) rx_sr <= {rx_sr[6:0], mosi};
      if (tx_load)                      tx_sr <= sub_tx;
      else if (slave_transfer_shift_en) tx_sr <= {tx_sr[6:0], 1'b0};
    end
  end

  assign sub_rx = rx_sr;
  assign miso   = tx_sr[7];

  always @(posedge pclk) begin
    if (tx_load)                                n_load <= n_load + 1;
    if (slave_transfer_shift_en)                n_tsh  <= n_tsh + 1;
    if (slave_receive_shift_en)                 n_rsh  <= n_rsh + 1;
    if (tx_load && slave_transfer_shift_en)     n_both <= n_both + 1;
    if (rx_valid && rx_ready)                   rx_q.push_back(rx_data);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic set_mode(input logic p, input logic h);
    cpol = p; cpha = h; sclk_pad_i = p;
    cyc(H);
  endtask

  task automatic cs_low();
    cs_n_pad_i = 1'b0;
    cyc(H);
  endtask

  task automatic cs_high();
    cyc(2);
    cs_n_pad_i = 1'b1;
    cyc(H);
  endtask

  task automatic clr();
    clr_status = 1'b1;
    cyc(1);
    clr_status = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    int t = 0;
    while (!tx_ready && t < 100) begin
      cyc(1);
      t++;
    end
    chk("push_rdy", tx_ready, 1);
    tx_data = d; tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
  endtask

  // Host side: drives MOSI MSB first and samples MISO on the sampling edge.
  task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] got);
    got = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        mosi = b[i];
        cyc(H);
        sclk_pad_i = ~cpol;
        got = {got[6:0], miso};
        cyc(H);
        sclk_pad_i = cpol;
      end else begin
        sclk_pad_i = ~cpol;
        mosi = b[i];
        cyc(H);
        sclk_pad_i = cpol;
        got = {got[6:0], miso};
        cyc(H);
      end
    end
    cyc(H);
  endtask

  initial begin
    logic [7:0] m;
    logic [7:0] e;
    int l0, t0, r0, q0;

    cyc(3);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_sub_tx", sub_tx, 8'hFF);
    chk("rst_busy", busy, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_ovr", rx_overrun, 0);
    chk("rst_udr", tx_underrun, 0);
    chk("rst_load", tx_load, 0);
    chk("rst_bcnt", frame_byte_cnt, 0);
    presetn = 1'b1;
    cyc(3);

    // Mode 0: host sends A5, subordinate returns 3C
    set_mode(1'b0, 1'b0);
    rx_ready = 1'b0;
    push(8'h3C);
    l0 = n_load; t0 = n_tsh; r0 = n_rsh;
    cs_low();
    chk("m0_busy", busy, 1);
    chk("m0_load_cs", n_load - l0, 1);
    chk("m0_hold_taken", tx_ready, 1);
    chk("m0_no_udr", tx_underrun, 0);
    spi_bits(8'hA5, 8, m);
    chk("m0_miso", m, 8'h3C);
    chk("m0_rsh", n_rsh - r0, 8);
    chk("m0_tsh", n_tsh - t0, 7);
    chk("m0_loads", n_load - l0, 2);
    chk("m0_rx_data", rx_data, 8'hA5);
    chk("m0_rx_valid", rx_valid, 1);
    chk("m0_udr", tx_underrun, 1);
    cs_high();
    chk("m0_idle", busy, 0);
    clr();
    chk("m0_clr_udr", tx_underrun, 0);
    rx_ready = 1'b1;
    cyc(2);
    chk("m0_drained", rx_valid, 0);

    // Empty holding register at frame start sends the dummy byte
    cs_low();
    spi_bits(8'h0F, 8, m);
    cs_high();
    chk("empty_miso", m, 8'hFF);
    chk("empty_udr", tx_underrun, 1);
    chk("idle_sub_tx", sub_tx, 8'hFF);
    clr();
    chk("empty_clr", tx_underrun, 0);

    // Mode 3: two bytes in one frame
    set_mode(1'b1, 1'b1);
    push(8'h5A);
    q0 = rx_q.size();
    cs_low();
    spi_bits(8'h12, 8, m);
    chk("m3_miso0", m, 8'h5A);
    push(8'h96);
    spi_bits(8'h34, 8, m);
    chk("m3_miso1", m, 8'h96);
    cs_high();
    chk("m3_nrx", rx_q.size() - q0, 2);
    e = (rx_q.size() > q0) ? rx_q[q0] : 8'h00;
    chk("m3_rx0", e, 8'h12);
    e = (rx_q.size() > q0 + 1) ? rx_q[q0+1] : 8'h00;
    chk("m3_rx1", e, 8'h34);
    chk("m3_udr", tx_underrun, 0);
`ifdef SPI_SUB_CTRL_BYTE_CNT_EN
    chk("m3_bcnt", frame_byte_cnt, 2);
`else
    chk("m3_bcnt", frame_byte_cnt, 0);
`endif

    // Overrun: consumer stalled across two bytes
    set_mode(1'b0, 1'b0);
    rx_ready = 1'b0;
    cs_low();
    spi_bits(8'h55, 8, m);
    spi_bits(8'hAA, 8, m);
    cs_high();
    chk("ovr_rx_data", rx_data, 8'h55);
    chk("ovr_rx_valid", rx_valid, 1);
    chk("ovr_flag", rx_overrun, 1);
    clr();
    chk("ovr_clr", rx_overrun, 0);
    rx_ready = 1'b1;
    cyc(2);
    chk("ovr_drained", rx_valid, 0);
    clr();

    // Mode 1: frame aborted after 4 bits, then a clean frame
    set_mode(1'b0, 1'b1);
    q0 = rx_q.size();
    push(8'hE7);
    cs_low();
    spi_bits(8'hF0, 4, m);
    cs_high();
    chk("abort_busy", busy, 0);
    chk("abort_bitcnt", dut.bit_cnt, 0);
    chk("abort_nrx", rx_q.size() - q0, 0);
    chk("abort_rx_valid", rx_valid, 0);
    push(8'h24);
    cs_low();
    spi_bits(8'hC3, 8, m);
    cs_high();
    chk("m1_miso", m, 8'h24);
    chk("m1_nrx", rx_q.size() - q0, 1);
    e = (rx_q.size() > q0) ? rx_q[q0] : 8'h00;
    chk("m1_rx", e, 8'hC3);

    // Reset asserted mid-frame
    set_mode(1'b0, 1'b0);
    push(8'h77);
    cs_low();
    spi_bits(8'hFF, 3, m);
    presetn = 1'b0;
    #1;
    chk("mr_tx_ready", tx_ready, 1);
    chk("mr_sub_tx", sub_tx, 8'hFF);
    chk("mr_busy", busy, 0);
    chk("mr_rx_data", rx_data, 0);
    chk("mr_rx_valid", rx_valid, 0);
    chk("mr_load", tx_load, 0);
    chk("mr_tsh", slave_transfer_shift_en, 0);
    chk("mr_rsh", slave_receive_shift_en, 0);
    chk("mr_ovr", rx_overrun, 0);
    chk("mr_udr", tx_underrun, 0);
    chk("mr_bcnt", frame_byte_cnt, 0);
    cs_n_pad_i = 1'b1;
    sclk_pad_i = 1'b0;
    cyc(3);
    presetn = 1'b1;
    cyc(4);
    push(8'h81);
    q0 = rx_q.size();
    cs_low();
    spi_bits(8'h3E, 8, m);
    cs_high();
    chk("ar_miso", m, 8'h81);
    chk("ar_nrx", rx_q.size() - q0, 1);
    e = (rx_q.size() > q0) ? rx_q[q0] : 8'h00;
    chk("ar_rx", e, 8'h3E);

    chk("load_shift_overlap", n_both, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
